oam_dma_engine: RTL and testbench
=================================

// Module: oam_dma_engine
// PURPOSE
//  OAM DMA master. It sits upstream of the memory unit, on its CPU-side bus port.
//  A CPU write to FF46 loads dma_page and pulses dma_start. The engine then copies
//  160 bytes from {src_page,8'h00} to FE00..FE9F, one byte at a time.
//  While it runs, bus_req steals the memory bus from the CPU through the bus mux.
// PARAMETERS
//  OAM_BASE  16'hFE00  destination base address
//  XFER_LEN  160       bytes per transfer; counter width is $clog2(XFER_LEN)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, asynchronous, active-high
//  dma_start  in   1   1-cycle pulse on CPU write to FF46
//  dma_page   in   8   source page written to FF46; sampled when dma_start=1
//  mem_rdata  in   8   memory read data; valid in the data phase of a read
//  bus_req    out  1   engine owns the memory bus (mux selects DMA)
//  mem_addr   out  16  address phase output (memory registers it at posedge)
//  mem_oe     out  1   read data phase strobe
//  mem_we     out  1   write data phase strobe
//  mem_wdata  out  8   write data, valid while mem_we=1
//  busy       out  1   transfer in progress (same as bus_req)
//  done       out  1   1-cycle pulse after the final OAM write
// BEHAVIOUR
//  Bus protocol (memory unit registers the address):
//   - an address driven in cycle t is used in data phase t+1;
//   - OE/WE/wdata are driven in t+1; writes commit at the end of t+1.
//   - The next address phase overlaps the current data phase.
//  Source page remap: src_page = (dma_page >= 8'hE0) ? dma_page - 8'h20 : dma_page.
//   e.g. FE->DE, E0->C0.
//  FSM (dma_state_t):
//   IDLE: all outputs 0. On dma_start: latch src_page, idx<=0, go to PRIME.
//   PRIME: mem_addr={src,idx}. Go to RD.
//   RD: mem_oe=1. Capture mem_rdata into data_q at posedge.
//       mem_addr=OAM_BASE+idx. Go to WR.
//   WR: mem_we=1, mem_wdata=data_q.
//       If idx==XFER_LEN-1: mem_addr=0, go to FIN.
//       Else: idx<=idx+1, mem_addr={src,idx+1}, go to RD.
//   FIN: done=1 (bus_req=0). Go to IDLE.
//   bus_req=busy=1 in PRIME, RD and WR only.
//  Latency: dma_start in cycle 0 -> busy is high cycles 1..321 (1+2*160) -> done in cycle 322.
//  Restart: dma_start in any busy state re-latches the page and forces idx=0.
//   FSM goes to PRIME next cycle. A WR in that cycle still completes.
//  Restart in FIN: restart wins; done still pulses.
//  dma_start with dma_page unchanged restarts anyway (no filtering).
//  Reset (any cycle, including mid-transfer): state=IDLE, idx=0, data_q=0.
//   All outputs 0 immediately (async). No further memory strobes.
//  mem_addr low byte = idx, which never exceeds 8'h9F; no carry into the page.
//  Outputs are registered-state decodes. No combinational path from mem_rdata to any output.
// STRUCTURE
//  constants.sv: OAM_BASE, DMA_LEN, FF46 address constant, dma_state_t enum
//   (IDLE, PRIME, RD, WR, FIN).
//  Sub-module oam_dma_bus_mux: selects {mem_addr, mem_oe, mem_we, data} vs the CPU
//   bus on bus_req. It holds CPU OE/WE low while bus_req=1.
//  FSM, index counter and data_q stay in oam_dma_engine.
// TESTING
//  1. Preload C100+i=i^8'h5A; dma_page=C1.
//     -> reads C100..C19F; writes FE00..FE9F with the same bytes;
//        busy for 321 cycles; done in cycle 322.
//  2. dma_page=FE -> source addresses DE00..DE9F. dma_page=E3 -> C300..C39F.
//  3. Restart with page C2 while idx=50 (in RD).
//     -> next cycle is PRIME, addr C200; FE00..FE9F end up holding page C2 data;
//        a single done pulse.
//  4. Assert rst while idx=80, mid-WR.
//     -> bus_req/oe/we drop the same cycle; FE51+ not written;
//        next dma_start runs a full transfer.
//  5. dma_start in FIN.
//     -> done pulses; busy rises next cycle; a full 160-byte transfer follows.
//  6. Protocol check: oe and we never both 1.
//     -> every WR uses the address from the preceding cycle;
//        bus_req=0 outside PRIME/RD/WR.

Source files
------------

// File: rtl/oam_dma_engine_pkg.sv
// Shared constants, FSM state type and source-page remap for the OAM DMA engine.
package oam_dma_engine_pkg;

    localparam logic [15:0] DEF_OAM_BASE = 16'hFE00;
    localparam int          DMA_LEN      = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RD,
        WR,
        FIN
    } dma_state_t;

    // Echo RAM pages E0..FF alias work RAM C0..DF, so the engine reads the real RAM.
    function automatic logic [7:0] src_page_remap(input logic [7:0] page);
        return (page >= 8'hE0) ? (page - 8'h20) : page;
    endfunction

endpackage

// File: rtl/oam_dma_engine_if.sv
// DMA control, engine-side memory bus, CPU-side bus and the muxed memory-unit bus.
interface oam_dma_engine_if;

    logic        dma_start;
    logic [7:0]  dma_page;
    logic [7:0]  mem_rdata;

    logic        bus_req;
    logic [15:0] mem_addr;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;

    logic [15:0] cpu_addr;
    logic        cpu_oe;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;

    logic [15:0] bus_addr;
    logic        bus_oe;
    logic        bus_we;
    logic [7:0]  bus_wdata;

    modport master (
        input  dma_start, dma_page, mem_rdata,
        input  cpu_addr, cpu_oe, cpu_we, cpu_wdata,
        output bus_req, mem_addr, mem_oe, mem_we, mem_wdata, busy, done,
        output bus_addr, bus_oe, bus_we, bus_wdata
    );

    modport slave (
        output dma_start, dma_page, mem_rdata,
        output cpu_addr, cpu_oe, cpu_we, cpu_wdata,
        input  bus_req, mem_addr, mem_oe, mem_we, mem_wdata, busy, done,
        input  bus_addr, bus_oe, bus_we, bus_wdata
    );

endinterface

// File: rtl/oam_dma_bus_mux.sv
// Memory-unit bus select: the DMA engine owns the bus while bus_req is high,
// and the CPU strobes are forced low for that whole window.
module oam_dma_bus_mux (
    input  logic        bus_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_oe,
    input  logic        dma_we,
    input  logic [7:0]  dma_wdata,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [15:0] mem_addr,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [7:0]  mem_wdata
);

    logic cpu_oe_gated;
    logic cpu_we_gated;

    always_comb begin
        cpu_oe_gated = cpu_oe & ~bus_req;
        cpu_we_gated = cpu_we & ~bus_req;
        if (bus_req) begin
            mem_addr  = dma_addr;
            mem_oe    = dma_oe;
            mem_we    = dma_we;
            mem_wdata = dma_wdata;
        end else begin
            mem_addr  = cpu_addr;
            mem_oe    = cpu_oe_gated;
            mem_we    = cpu_we_gated;
            mem_wdata = cpu_wdata;
        end
    end

endmodule

// File: rtl/oam_dma_engine.sv
// OAM DMA master: copies XFER_LEN bytes from {src_page,00} to OAM_BASE, one
// read/write pair per byte, with read and write address phases overlapping data phases.
module oam_dma_engine
    import oam_dma_engine_pkg::*;
#(
    parameter logic [15:0] OAM_BASE = DEF_OAM_BASE,
    parameter int          XFER_LEN = DMA_LEN
) (
    input  logic              clk,
    input  logic              rst,
    oam_dma_engine_if.master  dma_if
);

    localparam int                IDX_W    = $clog2(XFER_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(XFER_LEN - 1);

    dma_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        src_q, src_d;

    logic [15:0]       dma_addr;
    logic              dma_oe;
    logic              dma_we;
    logic [7:0]        dma_wdata;
    logic              busy;
    logic              done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    // Outputs decode registered state only; mem_rdata reaches nothing but data_q.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        src_d     = src_q;
        dma_addr  = '0;
        dma_oe    = 1'b0;
        dma_we    = 1'b0;
        dma_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
            end
            PRIME: begin
                busy     = 1'b1;
                dma_addr = {src_q, 8'(idx_q)};
                state_d  = RD;
            end
            RD: begin
                busy     = 1'b1;
                dma_oe   = 1'b1;
                data_d   = dma_if.mem_rdata;
                dma_addr = OAM_BASE + 16'(idx_q);
                state_d  = WR;
            end
            WR: begin
                busy      = 1'b1;
                dma_we    = 1'b1;
                dma_wdata = data_q;
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    // Next source read overlaps this write's data phase.
                    idx_d    = idx_q + IDX_W'(1);
                    dma_addr = {src_q, 8'(idx_q + IDX_W'(1))};
                    state_d  = RD;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start pulse always wins: fresh page, index back to zero, re-prime.
        if (dma_if.dma_start) begin
            src_d   = src_page_remap(dma_if.dma_page);
            idx_d   = '0;
            state_d = PRIME;
        end
    end

    assign dma_if.bus_req   = busy;
    assign dma_if.busy      = busy;
    assign dma_if.done      = done;
    assign dma_if.mem_addr  = dma_addr;
    assign dma_if.mem_oe    = dma_oe;
    assign dma_if.mem_we    = dma_we;
    assign dma_if.mem_wdata = dma_wdata;

    oam_dma_bus_mux u_bus_mux (
        .bus_req   (busy),
        .dma_addr  (dma_addr),
        .dma_oe    (dma_oe),
        .dma_we    (dma_we),
        .dma_wdata (dma_wdata),
        .cpu_addr  (dma_if.cpu_addr),
        .cpu_oe    (dma_if.cpu_oe),
        .cpu_we    (dma_if.cpu_we),
        .cpu_wdata (dma_if.cpu_wdata),
        .mem_addr  (dma_if.bus_addr),
        .mem_oe    (dma_if.bus_oe),
        .mem_we    (dma_if.bus_we),
        .mem_wdata (dma_if.bus_wdata)
    );

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: memory model behind the bus mux plus a cycle-offset
// reference model of each transfer, driven by random pages, data and restarts.
module tb_oam_dma_engine;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    oam_dma_engine_if dif ();

    oam_dma_engine #(
        .OAM_BASE (16'hFE00),
        .XFER_LEN (160)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .dma_if (dif.master)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          done_cnt = 0;

    logic [7:0]  src_mem [0:65535];
    logic [7:0]  oam_mem [0:159];
    int          oam_ep  [0:159];
    logic [15:0] addr_reg = 16'h0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_src(input logic [7:0] p);
        return (p >= 8'hE0) ? p - 8'h20 : p;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory unit: registered address, read data in the following cycle, writes commit at its end.
    assign dif.mem_rdata = src_mem[addr_reg];

    always @(posedge clk) begin
        if (dif.bus_we && dif.bus_req && addr_reg >= 16'hFE00 && addr_reg < 16'hFEA0) begin
            oam_mem[addr_reg[7:0]] <= dif.bus_wdata;
            oam_ep[addr_reg[7:0]]  <= epoch;
        end
        addr_reg <= dif.bus_addr;
    end

    // CPU side keeps toggling; the mux must hide it while the engine owns the bus.
    initial begin
        dif.cpu_addr  = 16'h0000;
        dif.cpu_oe    = 1'b0;
        dif.cpu_we    = 1'b0;
        dif.cpu_wdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            dif.cpu_addr  = 16'($urandom);
            dif.cpu_oe    = 1'($urandom);
            dif.cpu_we    = 1'($urandom);
            dif.cpu_wdata = 8'($urandom);
        end
    end

    // Reference model: a transfer started in cycle s spends offset k = cyc-s-1 in
    // 0 (prime), odd k (read byte (k-1)/2), even k>=2 (write byte (k-2)/2), 321 (done).
    bit          act = 1'b0;
    int          st_cyc = 0;
    logic [7:0]  m_src = 8'h00;
    int          k;
    int          bi;
    logic [15:0] e_addr;
    logic        e_oe, e_we, e_busy, e_done;
    logic [7:0]  e_wd;
    logic [7:0]  o_wd;

    always @(negedge clk) begin
        e_addr = 16'h0000; e_oe = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_wd = 8'h00;
        k = -1; bi = 0;
        if (rst) begin
            act = 1'b0;
        end else if (act) begin
            k = cyc - st_cyc - 1;
            if (k == 0) begin
                e_busy = 1'b1;
                e_addr = {m_src, 8'h00};
            end else if (k <= 320 && (k % 2) == 1) begin
                bi = (k - 1) / 2;
                e_busy = 1'b1;
                e_oe   = 1'b1;
                e_addr = 16'hFE00 + 16'(bi);
            end else if (k <= 320) begin
                bi = (k - 2) / 2;
                e_busy = 1'b1;
                e_we   = 1'b1;
                e_wd   = src_mem[{m_src, 8'(bi)}];
                e_addr = (bi == 159) ? 16'h0000 : {m_src, 8'(bi + 1)};
            end else begin
                e_done = 1'b1;
            end
            if (k >= 321) act = 1'b0;
        end
        if (dif.done) done_cnt++;

        o_wd = dif.mem_we ? dif.mem_wdata : 8'h00;
        chk("engine_out",
            64'({dif.busy, dif.bus_req, dif.mem_oe, dif.mem_we, dif.done, dif.mem_addr, o_wd}),
            64'({e_busy, e_busy, e_oe, e_we, e_done, e_addr, e_wd}));
        chk("mux_out",
            64'({dif.bus_addr, dif.bus_oe, dif.bus_we, (e_busy && !e_we) ? 8'h00 : dif.bus_wdata}),
            e_busy ? 64'({e_addr, e_oe, e_we, e_wd})
                   : 64'({dif.cpu_addr, dif.cpu_oe, dif.cpu_we, dif.cpu_wdata}));
        chk("oe_we_excl", 64'(dif.mem_oe & dif.mem_we), 64'(0));
        if (e_we) chk("wr_addr_prev", 64'(addr_reg), 64'(16'hFE00 + 16'(bi)));

        if (!rst && dif.dma_start) begin
            act    = 1'b1;
            st_cyc = cyc;
            m_src  = ref_src(dif.dma_page);
        end
    end

    task automatic start_pulse(input logic [7:0] page);
        dif.dma_start = 1'b1;
        dif.dma_page  = page;
        @(posedge clk);
        #1;
        dif.dma_start = 1'b0;
        dif.dma_page  = 8'($urandom);
    endtask

    // Counts negedges until done; a missing done shows up as a wrong count.
    task automatic wait_done(input int exp_n, input string tag);
        int  n;
        bit  found;
        n = 0;
        found = 1'b0;
        while (n < 400 && !found) begin
            @(negedge clk);
            n++;
            if (dif.done) found = 1'b1;
        end
        chk(tag, 64'(n), 64'(exp_n));
        @(posedge clk);
        #1;
    endtask

    task automatic check_oam(input logic [7:0] page, input int lo, input int hi, input string tag);
        logic [7:0] sp;
        sp = ref_src(page);
        for (int i = lo; i < hi; i++)
            chk(tag, 64'({32'(oam_ep[i]), oam_mem[i]}), 64'({32'(epoch), src_mem[{sp, 8'(i)}]}));
    endtask

    logic [7:0] pg, pg2;
    int         d0;

    initial begin
        rst = 1'b1;
        dif.dma_start = 1'b0;
        dif.dma_page  = 8'h00;
        for (int a = 0; a < 65536; a++) src_mem[a] = 8'($urandom);
        for (int i = 0; i < 160; i++) begin
            src_mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
            oam_mem[i] = 8'h00;
            oam_ep[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({dif.busy, dif.bus_req, dif.mem_oe, dif.mem_we, dif.done, dif.mem_addr}), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Known pattern from page C1
        epoch++;
        start_pulse(8'hC1);
        wait_done(322, "t1_done_lat");
        check_oam(8'hC1, 0, 160, "t1_oam");
        chk("t1_byte7", 64'(oam_mem[7]), 64'(8'h07 ^ 8'h5A));

        // Echo-page remap
        epoch++;
        start_pulse(8'hFE);
        @(negedge clk);
        chk("t2_prime_fe", 64'(dif.mem_addr), 64'(16'hDE00));
        wait_done(321, "t2_done_fe");
        check_oam(8'hFE, 0, 160, "t2_oam_fe");
        epoch++;
        start_pulse(8'hE3);
        @(negedge clk);
        chk("t2_prime_e3", 64'(dif.mem_addr), 64'(16'hC300));
        wait_done(321, "t2_done_e3");
        check_oam(8'hE3, 0, 160, "t2_oam_e3");

        // Restart while reading byte 50
        epoch++;
        d0 = done_cnt;
        start_pulse(8'hC1);
        repeat (101) @(posedge clk);
        #1;
        chk("t3_in_rd50", 64'({dif.mem_oe, dif.mem_addr}), 64'({1'b1, 16'hFE32}));
        start_pulse(8'hC2);
        @(negedge clk);
        chk("t3_restart_prime", 64'({dif.busy, dif.mem_addr}), 64'({1'b1, 16'hC200}));
        wait_done(321, "t3_done");
        repeat (3) @(posedge clk);
        #1;
        chk("t3_single_done", 64'(done_cnt - d0), 64'(1));
        check_oam(8'hC2, 0, 160, "t3_oam");

        // Asynchronous reset in the write of byte 80
        epoch++;
        pg = 8'($urandom);
        start_pulse(pg);
        repeat (162) @(posedge clk);
        #1;
        chk("t4_in_wr80", 64'(dif.mem_we), 64'(1));
        rst = 1'b1;
        #1;
        chk("t4_async_drop", 64'({dif.busy, dif.bus_req, dif.mem_oe, dif.mem_we, dif.done}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_oam(pg, 0, 80, "t4_oam_head");
        for (int i = 81; i < 160; i++) chk("t4_no_wr_after_rst", 64'(oam_ep[i] == epoch), 64'(0));
        epoch++;
        pg = 8'($urandom);
        start_pulse(pg);
        wait_done(322, "t4_full_after_rst");
        check_oam(pg, 0, 160, "t4_oam_full");

        // Start arriving in the done cycle
        epoch++;
        pg  = 8'($urandom);
        pg2 = 8'($urandom);
        d0  = done_cnt;
        start_pulse(pg);
        repeat (321) @(posedge clk);
        #1;
        dif.dma_start = 1'b1;
        dif.dma_page  = pg2;
        @(negedge clk);
        chk("t5_fin_done", 64'({dif.done, dif.busy}), 64'({1'b1, 1'b0}));
        @(posedge clk);
        #1;
        dif.dma_start = 1'b0;
        @(negedge clk);
        chk("t5_busy_next", 64'(dif.busy), 64'(1));
        wait_done(321, "t5_done");
        chk("t5_done_count", 64'(done_cnt - d0), 64'(2));
        check_oam(pg2, 0, 160, "t5_oam");

        // Random restarts at random offsets
        for (int r = 0; r < 3; r++) begin
            epoch++;
            pg  = 8'($urandom);
            pg2 = 8'($urandom);
            start_pulse(pg);
            repeat ($urandom_range(1, 330)) @(posedge clk);
            #1;
            start_pulse(pg2);
            wait_done(322, "rnd_done");
            check_oam(pg2, 0, 160, "rnd_oam");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
